// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifu_pkg
// Purpose : Shared types and constants for the instruction fetch unit:
//           fetch FSM state encoding, word size, default NOP word, fetch
//           timer width and a word-alignment helper.
// Revision: 1.0 - initial release
// ============================================================================
package ifu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } ifu_state_e;

  localparam int          WORD_BYTES  = 4;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Wide enough for any FETCH_TIMEOUT in 1..255.
  localparam int          TIMER_W     = 8;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_unit_if
// Purpose : Instruction memory request/acknowledge bus.
// Ports   : Mem_Req  - fetch request (master -> memory)
//           Mem_Addr - fetch byte address, stable while Mem_Req=1
//           Mem_Ack  - read data valid (memory -> master)
//           Mem_Data - read data word
//           modport master: fetch unit side; modport slave: memory side.
// Revision: 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if;

  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack;
  logic [31:0] Mem_Data;

  modport master (
    output Mem_Req,
    output Mem_Addr,
    input  Mem_Ack,
    input  Mem_Data
  );

  modport slave (
    input  Mem_Req,
    input  Mem_Addr,
    output Mem_Ack,
    output Mem_Data
  );

endinterface
`default_nettype wire

// File: rtl/ifu_pc_next.sv
`default_nettype none
// ============================================================================
// Module  : ifu_pc_next
// Purpose : Combinational next-PC selection.
//           pc_select=0 -> ra_value
//           pc_select=1 -> pc + (inc_select ? branch_offset : WORD_BYTES)
//           Addition is 32-bit modulo.
// Ports   : pc, ra_value, branch_offset (in, 32), pc_select, inc_select
//           (in, 1), next_pc (out, 32).
// Revision: 1.0 - initial release
// ============================================================================
module ifu_pc_next
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ra_value,
  input  logic [31:0] branch_offset,
  input  logic        pc_select,
  input  logic        inc_select,
  output logic [31:0] next_pc
);

  logic [31:0] w_increment;

  always_comb begin
    w_increment = 32'(WORD_BYTES);
    if (inc_select) begin
      w_increment = branch_offset;
    end
    next_pc = ra_value;
    if (pc_select) begin
      next_pc = pc + w_increment;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_unit
// Purpose : Owns PC, return-address (PC_Temp) and instruction register of
//           the multicycle core. Issues single word fetches over a req/ack
//           bus, times out stalled fetches and reports a sticky fault.
// Ports   : Clock, Reset (async, active-high)
//           PC_Enable, PC_Select, INC_Select, RA_Value, Branch_Offset
//             - PC update controls
//           IR_Enable - start a fetch at the current PC
//           mem       - instruction memory bus (master modport)
//           Instruction, PC, PC_Temp, Fetch_Busy, Fetch_Fault - status
// Config  : FETCH_ALIGN_CHECK_EN - when defined, a fetch from a PC that is
//           not word aligned is refused and raises Fetch_Fault.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 15,
  parameter logic [31:0] NOP_WORD      = NOP_DEFAULT
)
(
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            PC_Enable,
  input  logic                            PC_Select,
  input  logic                            INC_Select,
  input  logic                            IR_Enable,
  input  logic [31:0]                     RA_Value,
  input  logic [31:0]                     Branch_Offset,
  instruction_fetch_unit_if.master        mem,
  output logic [31:0]                     Instruction,
  output logic [31:0]                     PC,
  output logic [31:0]                     PC_Temp,
  output logic                            Fetch_Busy,
  output logic                            Fetch_Fault
);

  // Timer value seen on the last waiting REQ cycle; the timeout fires on
  // the edge that would take the timer to FETCH_TIMEOUT.
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(FETCH_TIMEOUT - 1);

  ifu_state_e           state_q,    state_d;
  logic [TIMER_W-1:0]   timer_q,    timer_d;
  logic [31:0]          pc_q,       pc_d;
  logic [31:0]          pc_temp_q,  pc_temp_d;
  logic [31:0]          instr_q,    instr_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic                 mem_req_q,  mem_req_d;
  logic                 fault_q,    fault_d;

  logic [31:0]          w_next_pc;
  logic                 w_align_ok;

  ifu_pc_next u_pc_next (
    .pc            (pc_q),
    .ra_value      (RA_Value),
    .branch_offset (Branch_Offset),
    .pc_select     (PC_Select),
    .inc_select    (INC_Select),
    .next_pc       (w_next_pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_align_ok = is_word_aligned(pc_q);
`else
  // Low address bits are passed through to memory untouched.
  assign w_align_ok = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pc_q       <= RESET_PC;
      pc_temp_q  <= '0;
      instr_q    <= NOP_WORD;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pc_q       <= pc_d;
      pc_temp_q  <= pc_temp_d;
      instr_q    <= instr_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      fault_q    <= fault_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pc_d       = pc_q;
    pc_temp_d  = pc_temp_q;
    instr_d    = instr_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    fault_d    = fault_q;

    // PC update is independent of the fetch FSM; the fetch address is
    // always taken from the pre-update pc_q.
    if (PC_Enable) begin
      pc_temp_d = pc_q;
      pc_d      = w_next_pc;
    end

    case (state_q)
      IDLE: begin
        if (IR_Enable) begin
          if (w_align_ok) begin
            mem_addr_d = pc_q;
            mem_req_d  = 1'b1;
            timer_d    = '0;
            state_d    = REQ;
          end else begin
            instr_d = NOP_WORD;
            fault_d = 1'b1;
          end
        end
      end

      REQ: begin
        // An ack on the timeout edge still delivers the data.
        if (mem.Mem_Ack) begin
          instr_d   = mem.Mem_Data;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          instr_d   = NOP_WORD;
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem.Mem_Req  = mem_req_q;
  assign mem.Mem_Addr = mem_addr_q;
  assign Instruction  = instr_q;
  assign PC           = pc_q;
  assign PC_Temp      = pc_temp_q;
  assign Fetch_Busy   = (state_q == REQ);
  assign Fetch_Fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch_unit
// Purpose : Self-checking bench for instruction_fetch_unit. A stimulus
//           process drives inputs on the falling edge and pushes the
//           reference model's expected post-edge state into a queue; an
//           independent monitor pops and compares after each rising edge.
//           Issued fetch addresses go through their own queue and are
//           checked when the DUT raises Mem_Req.
// Config  : FETCH_ALIGN_CHECK_EN selects the alignment-fault model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          FETCH_TIMEOUT = 15;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        pc_enable, pc_select, inc_select, ir_enable;
  logic [31:0] ra_value, branch_offset;
  logic [31:0] instruction, pc, pc_temp;
  logic        fetch_busy, fetch_fault;

  instruction_fetch_unit_if mem_bus ();

  instruction_fetch_unit #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (FETCH_TIMEOUT),
    .NOP_WORD      (NOP_WORD)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .PC_Enable     (pc_enable),
    .PC_Select     (pc_select),
    .INC_Select    (inc_select),
    .IR_Enable     (ir_enable),
    .RA_Value      (ra_value),
    .Branch_Offset (branch_offset),
    .mem           (mem_bus),
    .Instruction   (instruction),
    .PC            (pc),
    .PC_Temp       (pc_temp),
    .Fetch_Busy    (fetch_busy),
    .Fetch_Fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_temp;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        busy;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only.
  logic [31:0] m_pc, m_pc_temp, m_instr, m_addr;
  logic        m_busy, m_fault;
  int          m_waited;

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_pc_temp = 32'h0;
    m_instr   = NOP_WORD;
    m_addr    = 32'h0;
    m_busy    = 1'b0;
    m_fault   = 1'b0;
    m_waited  = 0;
  endtask

  // One clock of stimulus: drive at the falling edge, then advance the model
  // to the state expected after the next rising edge.
  task automatic cycle(input logic pe, input logic ps, input logic is,
                       input logic [31:0] ra, input logic [31:0] off,
                       input logic ir, input logic ack, input logic [31:0] data);
    exp_t e;
    @(negedge clk);
    pc_enable        = pe;
    pc_select        = ps;
    inc_select       = is;
    ra_value         = ra;
    branch_offset    = off;
    ir_enable        = ir;
    mem_bus.Mem_Ack  = ack;
    mem_bus.Mem_Data = data;

    if (!m_busy) begin
      if (ir) begin
        if (ALIGN_CHK && (m_pc % 4 != 0)) begin
          m_fault = 1'b1;
          m_instr = NOP_WORD;
        end else begin
          m_addr   = m_pc;
          m_busy   = 1'b1;
          m_waited = 0;
          addr_q.push_back(m_pc);
        end
      end
    end else if (ack) begin
      m_instr = data;
      m_busy  = 1'b0;
    end else begin
      m_waited = m_waited + 1;
      if (m_waited == FETCH_TIMEOUT) begin
        m_instr = NOP_WORD;
        m_fault = 1'b1;
        m_busy  = 1'b0;
      end
    end

    if (pe) begin
      m_pc_temp = m_pc;
      if (ps) m_pc = m_pc + (is ? off : 32'd4);
      else    m_pc = ra;
    end

    e.pc = m_pc; e.pc_temp = m_pc_temp; e.instr = m_instr;
    e.addr = m_addr; e.busy = m_busy; e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  // Reset asserted between edges: Mem_Req must fall without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'h0, mem_bus.Mem_Req}, 32'h0);
    chk("async_rst_busy", {31'h0, fetch_busy}, 32'h0);
    pc_enable = 0; pc_select = 0; inc_select = 0; ir_enable = 0;
    ra_value = 0; branch_offset = 0; mem_bus.Mem_Ack = 0; mem_bus.Mem_Data = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin
    exp_t e;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pc", pc, e.pc);
          chk("pc_temp", pc_temp, e.pc_temp);
          chk("instruction", instruction, e.instr);
          chk("fetch_busy", {31'h0, fetch_busy}, {31'h0, e.busy});
          chk("mem_req", {31'h0, mem_bus.Mem_Req}, {31'h0, e.busy});
          chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, e.fault});
          if (e.busy) chk("mem_addr_hold", mem_bus.Mem_Addr, e.addr);
        end
        if (mem_bus.Mem_Req && !prev_req) begin
          if (addr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_request actual_addr=%h required=no request", mem_bus.Mem_Addr);
          end else begin
            chk("issue_addr", mem_bus.Mem_Addr, addr_q.pop_front());
          end
        end
        prev_req = mem_bus.Mem_Req;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic pe, ps, is, ir, ack;
    logic [31:0] ra, off;

    rst = 1'b1;
    pc_enable = 0; pc_select = 0; inc_select = 0; ir_enable = 0;
    ra_value = 0; branch_offset = 0; mem_bus.Mem_Ack = 0; mem_bus.Mem_Data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_pc_temp", pc_temp, 32'h0);
    chk("rst_instruction", instruction, NOP_WORD);
    chk("rst_mem_req", {31'h0, mem_bus.Mem_Req}, 32'h0);
    chk("rst_mem_addr", mem_bus.Mem_Addr, 32'h0);
    chk("rst_busy", {31'h0, fetch_busy}, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Minimum-latency fetch.
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    idle(2);

    // Sequential increments, then a negative branch offset.
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 32'hFFFF_FFF8, 0, 0, 0);

    // Register jump, then wrap-around at the top of the address space.
    cycle(1, 0, 0, 32'h0000_0100, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);

    // Fetch and PC update on the same edge; a second IR_Enable while busy.
    cycle(1, 0, 0, 32'h0000_0020, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_0002);   // ack while idle
    idle(1);

    // Timeout: no ack at all.
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    idle(FETCH_TIMEOUT + 2);
    // Fault stays set across a successful fetch.
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
    idle(1);
    do_reset();
    idle(1);

    // Reset in the middle of an outstanding fetch; a late ack is ignored.
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
    idle(1);

    // Misaligned PC fetch.
    cycle(1, 0, 0, 32'h0000_0102, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h7777_0102);
    idle(1);
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      pe  = ($urandom % 2) == 0;
      ps  = ($urandom % 4) != 0;
      is  = ($urandom % 3) == 0;
      ra  = $urandom;
      if (($urandom % 8) != 0) ra[1:0] = 2'b00;
      off = {{20{ra[11]}}, ra[11:0]} & 32'hFFFF_FFFC;
      ir  = ($urandom % 3) == 0;
      ack = m_busy ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      cycle(pe, ps, is, ra, off, ir, ack, $urandom);
      if (n == 300) do_reset();
    end
    idle(2);
    @(posedge clk);
    #2;
    chk("exp_queue_drained", exp_q.size(), 32'h0);
    chk("addr_queue_drained", addr_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Owns the program counter, return-address register and instruction register for the multicycle core.
- Issues word fetches to instruction memory over a req/ack handshake and presents the fetched word to the control signal generator's Instruction input.
- Driven by the stage-level PC_Enable, PC_Select, INC_Select and IR_Enable controls.
- Raises a busy flag so the stage counter can hold while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 15, max cycles Mem_Req may wait for Mem_Ack before a fault (1..255).
- NOP_WORD, 32'h0000_0000, word loaded into Instruction on reset and on fault.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PC_Enable  in  1  update PC this cycle.
- PC_Select  in  1  0: PC <= RA_Value; 1: PC <= PC + increment.
- INC_Select  in  1  0: increment = 4; 1: increment = Branch_Offset.
- IR_Enable  in  1  start a fetch at the current PC.
- RA_Value  in  32  register-sourced jump target.
- Branch_Offset  in  32  sign-extended byte offset from the immediate block.
- Mem_Ack  in  1  instruction memory data valid.
- Mem_Data  in  32  instruction memory read data.
- Mem_Req  out  1  fetch request, held until ack or timeout.
- Mem_Addr  out  32  fetch address, stable while Mem_Req=1.
- Instruction  out  32  registered instruction word.
- PC  out  32  current program counter.
- PC_Temp  out  32  PC value before the last update (return address).
- Fetch_Busy  out  1  fetch outstanding.
- Fetch_Fault  out  1  sticky; set by timeout (or misalignment when enabled).

Behaviour:
- Reset values: PC=RESET_PC, PC_Temp=0, Instruction=NOP_WORD, Mem_Req=0, Mem_Addr=0, Fetch_Busy=0, Fetch_Fault=0, FSM=IDLE, timer=0.
- Reset mid-fetch drops Mem_Req immediately (asynchronous); a later Mem_Ack is ignored.
- PC update when PC_Enable=1:
  - PC_Temp <= PC.
  - PC <= PC_Select ? PC + (INC_Select ? Branch_Offset : 32'd4) : RA_Value.
  - Addition is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- FSM states IDLE, REQ.
  - IDLE: IR_Enable=1 latches Mem_Addr <= PC (pre-update value if PC_Enable is also 1), asserts Mem_Req, clears timer, moves to REQ.
  - REQ with Mem_Ack=1: Instruction <= Mem_Data, Mem_Req <= 0, go to IDLE. Minimum latency: IR_Enable at edge N, ack sampled at N+1, Instruction valid after N+1.
  - REQ without ack: timer++. When timer reaches FETCH_TIMEOUT: Instruction <= NOP_WORD, Fetch_Fault <= 1, Mem_Req <= 0, go to IDLE.
- Fetch_Busy = (state==REQ); combinational from state.
- IR_Enable while in REQ is ignored; no queueing.
- PC_Enable while in REQ updates PC but never Mem_Addr.
- Mem_Ack while in IDLE is ignored.
- Fetch_Fault clears only on Reset.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: in IDLE, IR_Enable with PC[1:0]!=0 issues no request. Fetch_Fault <= 1 and Instruction <= NOP_WORD on that edge; the FSM stays in IDLE.
- Undefined: the address is issued unchanged and the low bits are passed to memory.

Decomposition:
- Package ifu_pkg: FSM state enum (IDLE, REQ), WORD_BYTES=4, default NOP constant, timer width derivation (8 bits).
- Sub-module ifu_pc_next: combinational next-PC mux/adder (PC, RA_Value, Branch_Offset, PC_Select, INC_Select -> next_pc). Shared with the branch-target unit later.

Test Plan:
- Reset, then IR_Enable with Mem_Ack returned one cycle later carrying 32'h1234_5678 -> Mem_Addr=0, Instruction=32'h1234_5678, Fetch_Busy high exactly 1 cycle.
- PC_Enable, PC_Select=1, INC_Select=0, three times from PC=0 -> PC=12, PC_Temp=8; then INC_Select=1 with offset 32'hFFFF_FFF8 -> PC=4.
- PC_Select=0, RA_Value=32'h0000_0100 -> PC=0x100, PC_Temp=previous PC; PC=32'hFFFF_FFFC plus 4 -> PC=0.
- IR_Enable and PC_Enable on the same edge at PC=0x20 -> Mem_Addr=0x20, PC=0x24; a second IR_Enable during REQ issues no new request.
- No Mem_Ack with FETCH_TIMEOUT=15 -> Mem_Req drops after 15 REQ cycles, Instruction=NOP_WORD, Fetch_Fault=1 until Reset.
- Reset asserted during REQ -> Mem_Req=0 with no clock edge; with FETCH_ALIGN_CHECK_EN, PC=0x102 plus IR_Enable -> no Mem_Req and Fetch_Fault=1.
